top6_select_ctrl: RTL and testbench
===================================

# top6_select_ctrl

Sequential top-K selector that sits on top of the 16-to-8 max-comparator layer in the selectTOP6 path. It captures one 16-entry matrix of 13-bit values and time-multiplexes a single layer of eight max comparators over four reduction passes to find the current maximum. It then masks that winner out and repeats until K winners have been emitted. Results stream out one per handshake, in descending order, each tagged with its source index.

## Interface
Parameters:
- DATA_W, 13, width of each matrix entry (unsigned)
- K, 6, number of winners emitted per matrix (legal 1..16)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low (one clock; reset is asynchronous and active-low)
- in_valid  input  1  in_mat holds a new matrix
- in_ready  output  1  block is idle and will accept a matrix
- in_mat  input  DATA_W x [0:15]  unpacked input matrix
- out_valid  output  1  out_value/out_index/out_rank hold a winner
- out_ready  input  1  downstream accepts the current winner
- out_value  output  DATA_W  winning value
- out_index  output  4  position of the winner in in_mat
- out_rank  output  4  0 = largest, up to K-1
- out_last  output  1  high with the rank K-1 winner
- sel_mask  output  16  bit i set once entry i has been emitted in the current job
- busy  output  1  high from accept until the last handshake completes

## Operation
- Storage: value reg [0:15], live bit [0:15], and working arrays (value, index, live) of 16 slots.
- Comparator cell rule, for pair (a = slot 2j, b = slot 2j+1):
  - If only one slot is live, that slot wins.
  - If both are live, the larger value wins; on a tie, a wins (lower index).
  - If neither is live, the result is non-live with value 0 and index taken from a.
- States:
  - IDLE: in_ready = 1. On in_valid && in_ready, capture in_mat, set all live = 1, clear sel_mask, set rank = 0, then go to LOAD.
  - LOAD (1 cycle): copy stored value, live and index i into the 16 working slots. Set pass = 0 and go to REDUCE.
  - REDUCE (4 cycles, pass 0..3): one comparator layer reduces the working slots. The 16 slots become 8 on pass 0, then 4, 2 and 1 on passes 1..3. Unused upper slots are driven non-live. After pass 3, slot 0 holds the winner: register out_value, out_index and out_rank = rank, then go to EMIT.
  - EMIT: out_valid = 1. On out_ready:
    - clear live[out_index] and set sel_mask[out_index];
    - if rank == K-1, go to IDLE;
    - otherwise, increment rank and go to LOAD.
- Output stability: outputs are held stable while out_valid && !out_ready.
- Ignored inputs: in_valid is ignored outside IDLE, and in_mat is sampled only on accept.
- Duplicate values: because masking is by index, equal values are emitted in ascending index order.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1, busy = 0;
  - out_valid = 0, out_value = 0, out_index = 0, out_rank = 0, out_last = 0;
  - sel_mask = 0, all live = 0.
- Reset mid-job aborts immediately. No partial outputs follow, and the block is ready on the first edge after rst_n deasserts.
- Accept edge T: busy = 1 and in_ready = 0 from T. LOAD occupies T+1, and REDUCE occupies T+2..T+5.
- First out_valid rises after edge T+5, i.e. 5 cycles after accept.
- Per-rank cost is 5 cycles (1 LOAD + 4 REDUCE) plus EMIT wait.
- With out_ready held high, results appear every 6 cycles, and a full K = 6 job takes 36 cycles from accept to the last handshake.
- End of job: on the final handshake edge, out_valid drops, busy drops and in_ready rises. A new in_valid is accepted no earlier than the next cycle.
- Each handshake is one transfer: out_valid && out_ready on one edge. out_valid never asserts combinationally from out_ready.

## Test plan
- Distinct values: in_mat = {0,100,...,1500} (entry i = 100*i), out_ready tied high.
  - Required: indices 15,14,13,12,11,10 with values 1500..1000, ranks 0..5, out_last only on rank 5.
  - Required: first out_valid 5 cycles after accept, then every 6 cycles.
  - Required: sel_mask = 16'hFC00 after the job.
- Ties: all 16 entries = 8191.
  - Required: indices 0,1,2,3,4,5 in order, all values 8191.
- Backpressure: random values, out_ready low for 10 cycles at rank 2.
  - Required: out_value, out_index and out_rank stay constant with out_valid high, and no rank is skipped or duplicated.
- Input while busy: pulse in_valid with a second matrix during REDUCE.
  - Required: the pulse is ignored, the results match the first matrix only, and the second matrix is accepted only after in_ready returns to 1.
- Reset mid-operation: assert rst_n = 0 asynchronously during EMIT of rank 3.
  - Required: all outputs take reset values immediately.
  - Required: a new matrix {entry 7 = 42, others 0} then yields index 7 / value 42 at rank 0, followed by indices 0,1,2,3,4.
- K = 1 build: the job ends after one handshake, with out_last high on rank 0.

Source files
------------

// File: rtl/top6_select_ctrl_if.sv
// Handshake and status bundle for the sequential top-K selector.
// The slave side is the selector; the master side is whoever feeds matrices and drains winners.
interface top6_select_ctrl_if #(
  parameter int DATA_W = 13
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_mat [0:15];
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_value;
  logic [3:0]        out_index;
  logic [3:0]        out_rank;
  logic              out_last;
  logic [15:0]       sel_mask;
  logic              busy;

  modport master (
    output in_valid, in_mat, out_ready,
    input  in_ready, out_valid, out_value, out_index, out_rank, out_last, sel_mask, busy
  );

  modport slave (
    input  in_valid, in_mat, out_ready,
    output in_ready, out_valid, out_value, out_index, out_rank, out_last, sel_mask, busy
  );
endinterface

// File: rtl/top6_select_ctrl.sv
// Sequential top-K selector: one layer of eight max comparators reused over four
// passes finds the current maximum, which is emitted and masked out by index.
//
// state  | meaning
// IDLE   | waiting for a matrix, in_ready high
// LOAD   | copy stored values/live bits into the working slots
// REDUCE | four comparator passes, 16 -> 8 -> 4 -> 2 -> 1
// EMIT   | winner presented, waiting for out_ready
module top6_select_ctrl #(
  parameter int DATA_W = 13,
  parameter int K      = 6
) (
  input logic clk,
  input logic rst_n,
  top6_select_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, REDUCE, EMIT} state_t;

  localparam logic [3:0] LAST_RANK = 4'(K - 1);

  state_t state_q, state_d;

  logic [DATA_W-1:0] val_q [0:15];
  logic [15:0]       live_q;
  logic [DATA_W-1:0] wv [0:15];
  logic [3:0]        wi [0:15];
  logic              wl [0:15];
  logic [1:0]        pass_q;
  logic [3:0]        rank_q;

  logic [DATA_W-1:0] out_value_q;
  logic [3:0]        out_index_q;
  logic [3:0]        out_rank_q;
  logic [15:0]       sel_mask_q;

  logic [DATA_W-1:0] cmp_v [0:7];
  logic [3:0]        cmp_i [0:7];
  logic              cmp_l [0:7];

  // Comparator layer: b wins only when live and (a dead or strictly larger), so ties go to a.
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      cmp_v[j] = '0;
      cmp_i[j] = wi[2*j];
      cmp_l[j] = 1'b0;
      if (wl[2*j+1] && (!wl[2*j] || (wv[2*j+1] > wv[2*j]))) begin
        cmp_v[j] = wv[2*j+1];
        cmp_i[j] = wi[2*j+1];
        cmp_l[j] = 1'b1;
      end else if (wl[2*j]) begin
        cmp_v[j] = wv[2*j];
        cmp_l[j] = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = LOAD;
      LOAD:    state_d = REDUCE;
      REDUCE:  if (pass_q == 2'd3) state_d = EMIT;
      EMIT:    if (bus.out_ready) state_d = (rank_q == LAST_RANK) ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Matrix storage, working slots, rank/pass counters and registered winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        val_q[i] <= '0;
        wv[i]    <= '0;
        wi[i]    <= '0;
        wl[i]    <= 1'b0;
      end
      live_q      <= '0;
      pass_q      <= '0;
      rank_q      <= '0;
      out_value_q <= '0;
      out_index_q <= '0;
      out_rank_q  <= '0;
      sel_mask_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < 16; i++) val_q[i] <= bus.in_mat[i];
            live_q     <= '1;
            sel_mask_q <= '0;
            rank_q     <= '0;
          end
        end
        LOAD: begin
          for (int i = 0; i < 16; i++) begin
            wv[i] <= val_q[i];
            wl[i] <= live_q[i];
            wi[i] <= 4'(i);
          end
          pass_q <= '0;
        end
        REDUCE: begin
          for (int j = 0; j < 8; j++) begin
            wv[j] <= cmp_v[j];
            wi[j] <= cmp_i[j];
            wl[j] <= cmp_l[j];
          end
          for (int j = 8; j < 16; j++) begin
            wv[j] <= '0;
            wi[j] <= '0;
            wl[j] <= 1'b0;
          end
          pass_q <= 2'(pass_q + 2'd1);
          if (pass_q == 2'd3) begin
            out_value_q <= cmp_v[0];
            out_index_q <= cmp_i[0];
            out_rank_q  <= rank_q;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            live_q[out_index_q]     <= 1'b0;
            sel_mask_q[out_index_q] <= 1'b1;
            if (rank_q != LAST_RANK) rank_q <= 4'(rank_q + 4'd1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_value = out_value_q;
  assign bus.out_index = out_index_q;
  assign bus.out_rank  = out_rank_q;
  assign bus.out_last  = (state_q == EMIT) && (out_rank_q == LAST_RANK);
  assign bus.sel_mask  = sel_mask_q;

endmodule

// File: tb/tb_top6_select_ctrl.sv
// Scoreboard bench for the top-K selector (K=6 instance plus a K=1 instance).
module tb_top6_select_ctrl;

  typedef logic [12:0] mat_t [0:15];
  typedef struct packed {
    logic [12:0] v;
    logic [3:0]  i;
    logic [3:0]  r;
    logic        last;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;

  item_t exp_q[$];
  item_t exp1_q[$];

  top6_select_ctrl_if #(.DATA_W(13)) bif ();
  top6_select_ctrl_if #(.DATA_W(13)) bif1 ();

  top6_select_ctrl #(.DATA_W(13), .K(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bif.slave));
  top6_select_ctrl #(.DATA_W(13), .K(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bif1.slave));

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic cmp_item(input string nm, input item_t act, input item_t req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual v=%0d i=%0d r=%0d last=%0b required v=%0d i=%0d r=%0d last=%0b",
               nm, act.v, act.i, act.r, act.last, req.v, req.i, req.r, req.last);
    end
  endtask

  // Reference: linear scan for the largest unused entry, first index wins ties.
  function automatic void push_model(input mat_t m);
    logic [15:0] used = '0;
    int best;
    for (int r = 0; r < 6; r++) begin
      best = -1;
      for (int i = 0; i < 16; i++)
        if (!used[i] && (best < 0 || m[i] > m[best])) best = i;
      used[best] = 1'b1;
      exp_q.push_back('{v: m[best], i: 4'(best), r: 4'(r), last: (r == 5)});
    end
  endfunction

  // Scoreboard monitors: compare every completed handshake against the queue head.
  always @(negedge clk) begin
    if (rst_n && bif.out_valid && bif.out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", {19'd0, bif.out_value}, 32'hFFFF_FFFF);
      else cmp_item("out_item", {bif.out_value, bif.out_index, bif.out_rank, bif.out_last},
                    exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && bif1.out_valid && bif1.out_ready) begin
      if (exp1_q.size() == 0) check("k1_unexpected_out", {19'd0, bif1.out_value}, 32'hFFFF_FFFF);
      else cmp_item("k1_out_item", {bif1.out_value, bif1.out_index, bif1.out_rank, bif1.out_last},
                    exp1_q.pop_front());
    end
  end

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!bif.out_valid && n < 50) begin tick(1); n++; end
    if (!bif.out_valid) check({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (bif.busy && n < 200) begin tick(1); n++; end
    if (bif.busy) check({nm, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic send(input mat_t m);
    int n = 0;
    while (!bif.in_ready && n < 200) begin tick(1); n++; end
    if (!bif.in_ready) check("send_timeout", 32'd0, 32'd1);
    bif.in_mat   = m;
    bif.in_valid = 1'b1;
    tick(1);
    bif.in_valid = 1'b0;
  endtask

  task automatic hs();
    bif.out_ready = 1'b1;
    tick(1);
    bif.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mat_t m_dist, m_tie, m_bp, m_b, m_7;
    logic [12:0] hv;
    logic [3:0]  hi, hr;
    int bad;
    int n;

    for (int i = 0; i < 16; i++) begin
      m_dist[i] = 13'(100 * i);
      m_tie[i]  = 13'd8191;
      m_bp[i]   = 13'(((i * 37 + 11) % 97) * 50);
      m_b[i]    = 13'(8000 - 3 * i);
      m_7[i]    = 13'd0;
    end
    m_7[7] = 13'd42;

    bif.in_valid = 1'b0; bif.out_ready = 1'b0; bif.in_mat = m_dist;
    bif1.in_valid = 1'b0; bif1.out_ready = 1'b0; bif1.in_mat = m_dist;

    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, bif.in_ready}, 32'd1);
    check("rst_busy", {31'd0, bif.busy}, 32'd0);
    check("rst_out_valid", {31'd0, bif.out_valid}, 32'd0);
    check("rst_out_fields", {bif.out_value, bif.out_index, bif.out_rank, bif.out_last}, 32'd0);
    check("rst_sel_mask", {16'd0, bif.sel_mask}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Distinct values with out_ready high: latency and cadence.
    for (int r = 0; r < 6; r++)
      exp_q.push_back('{v: 13'(1500 - 100 * r), i: 4'(15 - r), r: 4'(r), last: (r == 5)});
    bif.out_ready = 1'b1;
    send(m_dist);
    check("dist_busy_after_accept", {30'd0, bif.busy, bif.in_ready}, 32'd2);
    for (int r = 0; r < 6; r++) begin
      tick(4);
      check($sformatf("dist_valid_low_r%0d", r), {31'd0, bif.out_valid}, 32'd0);
      tick(1);
      check($sformatf("dist_valid_high_r%0d", r), {31'd0, bif.out_valid}, 32'd1);
      tick(1);
    end
    check("dist_end_status", {29'd0, bif.out_valid, bif.busy, bif.in_ready}, 32'd1);
    check("dist_sel_mask", {16'd0, bif.sel_mask}, 32'h0000_FC00);
    check("dist_queue_empty", exp_q.size(), 32'd0);

    // All-equal values: ascending indices.
    for (int r = 0; r < 6; r++)
      exp_q.push_back('{v: 13'd8191, i: 4'(r), r: 4'(r), last: (r == 5)});
    send(m_tie);
    wait_idle("tie");
    check("tie_queue_empty", exp_q.size(), 32'd0);
    check("tie_sel_mask", {16'd0, bif.sel_mask}, 32'h0000_003F);

    // Backpressure: hold rank 2 for 10 cycles.
    bif.out_ready = 1'b0;
    push_model(m_bp);
    send(m_bp);
    for (int r = 0; r < 6; r++) begin
      wait_valid("bp");
      check($sformatf("bp_rank_%0d", r), {28'd0, bif.out_rank}, 32'(r));
      if (r == 2) begin
        hv = bif.out_value; hi = bif.out_index; hr = bif.out_rank;
        bad = 0;
        repeat (10) begin
          tick(1);
          if (!(bif.out_valid && bif.out_value == hv && bif.out_index == hi && bif.out_rank == hr))
            bad++;
        end
        check("bp_hold_stable", bad, 32'd0);
      end
      hs();
    end
    wait_idle("bp");
    check("bp_queue_empty", exp_q.size(), 32'd0);

    // in_valid pulse during REDUCE must be ignored.
    bif.out_ready = 1'b1;
    push_model(m_dist);
    send(m_dist);
    tick(1);
    check("busy_in_ready_low", {31'd0, bif.in_ready}, 32'd0);
    bif.in_mat = m_b;
    bif.in_valid = 1'b1;
    tick(1);
    bif.in_valid = 1'b0;
    wait_idle("busyin_a");
    check("busyin_a_queue_empty", exp_q.size(), 32'd0);
    push_model(m_b);
    send(m_b);
    wait_idle("busyin_b");
    check("busyin_b_queue_empty", exp_q.size(), 32'd0);
    check("busyin_b_sel_mask", {16'd0, bif.sel_mask}, 32'h0000_003F);

    // Asynchronous reset during EMIT of rank 3.
    bif.out_ready = 1'b0;
    push_model(m_dist);
    send(m_dist);
    for (int r = 0; r < 3; r++) begin
      wait_valid("rst_pre");
      hs();
    end
    wait_valid("rst_r3");
    check("rst_mid_rank", {28'd0, bif.out_rank}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_out_valid", {31'd0, bif.out_valid}, 32'd0);
    check("rstmid_out_fields", {bif.out_value, bif.out_index, bif.out_rank, bif.out_last}, 32'd0);
    check("rstmid_sel_mask", {16'd0, bif.sel_mask}, 32'd0);
    check("rstmid_status", {30'd0, bif.busy, bif.in_ready}, 32'd1);
    check("rstmid_pending", exp_q.size(), 32'd3);
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    exp_q.push_back('{v: 13'd42, i: 4'd7, r: 4'd0, last: 1'b0});
    for (int r = 1; r < 6; r++)
      exp_q.push_back('{v: 13'd0, i: 4'(r - 1), r: 4'(r), last: (r == 5)});
    bif.in_mat = m_7;
    bif.in_valid = 1'b1;
    tick(1);
    bif.in_valid = 1'b0;
    check("post_rst_accept", {31'd0, bif.busy}, 32'd1);
    bif.out_ready = 1'b1;
    wait_idle("post_rst");
    check("post_rst_queue_empty", exp_q.size(), 32'd0);
    check("post_rst_sel_mask", {16'd0, bif.sel_mask}, 32'h0000_009F);

    // K = 1 instance: single handshake ends the job.
    exp1_q.push_back('{v: 13'd1500, i: 4'd15, r: 4'd0, last: 1'b1});
    bif1.out_ready = 1'b1;
    bif1.in_mat = m_dist;
    bif1.in_valid = 1'b1;
    tick(1);
    bif1.in_valid = 1'b0;
    n = 0;
    while (bif1.busy && n < 50) begin tick(1); n++; end
    check("k1_job_cycles", n, 32'd6);
    check("k1_queue_empty", exp1_q.size(), 32'd0);
    check("k1_sel_mask", {16'd0, bif1.sel_mask}, 32'h0000_8000);
    check("k1_end_status", {30'd0, bif1.out_valid, bif1.in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
